// File: rtl/irq_controller_if.sv
// CPU-side register bus of the interrupt controller.
// The CPU drives the master end and the controller sits on the slave end.
interface irq_controller_if;
  logic [3:0]  wr;
  logic        rd;
  logic        select;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output wr,
    output rd,
    output select,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  wr,
    input  rd,
    input  select,
    input  addr,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: per-source pending/enable, edge or level mode,
// global enable and a fixed-priority vector register feeding the CPU interrupt request.
module irq_controller #(
  parameter int unsigned NUM_SOURCES = 8,
  parameter logic [31:0] EDGE_MASK   = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  irq_controller_if.slave        bus,
  input  logic [NUM_SOURCES-1:0] src,
  output logic                   irq
);

  localparam int unsigned N = NUM_SOURCES;

  localparam logic [1:0] AddrPending = 2'd0;
  localparam logic [1:0] AddrEnable  = 2'd1;
  localparam logic [1:0] AddrVector  = 2'd2;
  localparam logic [1:0] AddrControl = 2'd3;

  logic [N-1:0] src_q;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] enable_q, enable_d;
  logic         global_en_q, global_en_d;
  logic         irq_d;
  logic         wr_en;
  logic         active;
  logic [4:0]   idx;
  logic [31:0]  rdata;

  // Reads are side-effect free, so the read strobe carries no information here.
  logic unused_bus;
  assign unused_bus = ^{bus.rd, bus.data_in};

  assign wr_en = bus.select & (|bus.wr);

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < int'(N); i++) begin
      if (EDGE_MASK[i]) begin
        // A new rising edge beats a simultaneous W1C clear.
        pending_d[i] = (src[i] & ~src_q[i]) |
                       (pending_q[i] & ~(wr_en && (bus.addr == AddrPending) && bus.data_in[i]));
      end else begin
        pending_d[i] = src[i];
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    if (wr_en && (bus.addr == AddrEnable)) begin
      for (int i = 0; i < int'(N); i++) begin
        if (bus.wr[i >> 3]) begin
          enable_d[i] = bus.data_in[i];
        end
      end
    end
  end

  always_comb begin
    global_en_d = global_en_q;
    if (wr_en && (bus.addr == AddrControl) && bus.wr[0]) begin
      global_en_d = bus.data_in[0];
    end
  end

  // Scan from the top so the lowest active index is the one left standing.
  always_comb begin
    active = |(pending_q & enable_q);
    idx    = 5'd0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (pending_q[i] && enable_q[i]) begin
        idx = 5'(i);
      end
    end
  end

  assign irq_d = global_en_q & active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q       <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      global_en_q <= 1'b0;
      irq         <= 1'b0;
    end else begin
      src_q       <= src;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      global_en_q <= global_en_d;
      irq         <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (bus.addr)
      AddrPending: rdata[N-1:0] = pending_q;
      AddrEnable:  rdata[N-1:0] = enable_q;
      AddrVector: begin
        rdata[31]  = active;
        rdata[4:0] = idx;
      end
      AddrControl: rdata[0] = global_en_q;
      default:     rdata = '0;
    endcase
  end

  assign bus.data_out = rdata;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: table-driven per-cycle vectors checked
// through an expectation queue, plus hand sequences for reset behaviour.
module tb_irq_controller;

  localparam logic [1:0] P = 2'd0;
  localparam logic [1:0] E = 2'd1;
  localparam logic [1:0] V = 2'd2;
  localparam logic [1:0] C = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] src = 8'h00;
  logic       irq;

  irq_controller_if bus ();

  irq_controller #(
    .NUM_SOURCES(8),
    .EDGE_MASK  (32'h0000_000F)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .src  (src),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  src;
    logic [3:0]  wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  chk;
    logic [31:0] exp_d;
    logic        exp_irq;
  } vec_t;

  typedef struct {
    int          tag;
    logic [1:0]  chk;
    logic [31:0] exp_d;
    logic        exp_irq;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic drive(input logic [7:0] s, input logic [3:0] w, input logic [1:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    src          = s;
    bus.wr       = w;
    bus.addr     = a;
    bus.data_in  = d;
    bus.select   = 1'b1;
    bus.rd       = (w == 4'h0);
    @(posedge clk);
    #1;
    bus.wr      = 4'h0;
    bus.data_in = 32'h0;
  endtask

  task automatic expect_push(input int tag, input logic [1:0] a, input logic [31:0] d,
                             input logic i);
    exp_t e;
    e.tag = tag; e.chk = a; e.exp_d = d; e.exp_irq = i;
    exp_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expectation queued, got 0 entries want 1");
      return;
    end
    e = exp_q.pop_front();
    bus.addr = e.chk;
    #1;
    checks++;
    if (bus.data_out !== e.exp_d) begin
      errors++;
      $display("FAIL step %0d data_out[addr %0d]: got %h want %h", e.tag, e.chk,
               bus.data_out, e.exp_d);
    end
    checks++;
    if (irq !== e.exp_irq) begin
      errors++;
      $display("FAIL step %0d irq: got %b want %b", e.tag, irq, e.exp_irq);
    end
  endtask

  task automatic chk(input int tag, input logic [1:0] a, input logic [31:0] d, input logic i);
    expect_push(tag, a, d, i);
    check_pop();
  endtask

  task automatic add(input logic [7:0] s, input logic [3:0] w, input logic [1:0] a,
                     input logic [31:0] d, input logic [1:0] c, input logic [31:0] ed,
                     input logic ei);
    vec_t v;
    v.src = s; v.wr = w; v.addr = a; v.wdata = d; v.chk = c; v.exp_d = ed; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Edge-triggered pulse on src[2]; W1C drops irq one clock later.
    add(8'h00, 4'hF, E, 32'h04, E, 32'h04, 1'b0);
    add(8'h00, 4'h1, C, 32'h01, C, 32'h01, 1'b0);
    add(8'h04, 4'h0, P, 32'h00, P, 32'h04, 1'b0);
    add(8'h00, 4'h0, P, 32'h00, V, 32'h8000_0002, 1'b1);
    add(8'h00, 4'hF, P, 32'h04, P, 32'h00, 1'b1);
    add(8'h00, 4'h0, P, 32'h00, V, 32'h00, 1'b0);
    // Level source 5 ignores W1C and follows src.
    add(8'h20, 4'hF, E, 32'h20, P, 32'h20, 1'b0);
    add(8'h20, 4'h0, P, 32'h00, V, 32'h8000_0005, 1'b1);
    add(8'h20, 4'hF, P, 32'h20, P, 32'h20, 1'b1);
    add(8'h00, 4'h0, P, 32'h00, P, 32'h00, 1'b1);
    add(8'h00, 4'h0, P, 32'h00, V, 32'h00, 1'b0);
    // Priority among sources 1, 3 and 6.
    add(8'h4A, 4'hF, E, 32'h48, V, 32'h8000_0003, 1'b0);
    add(8'h40, 4'h0, P, 32'h00, P, 32'h4A, 1'b1);
    add(8'h40, 4'hF, P, 32'h08, V, 32'h8000_0006, 1'b1);
    add(8'h40, 4'hF, E, 32'h00, V, 32'h00, 1'b1);
    add(8'h40, 4'h0, P, 32'h00, P, 32'h42, 1'b0);
    add(8'h00, 4'hF, P, 32'hFF, P, 32'h00, 1'b0);
    // Set beats W1C in the same cycle; held-high source does not re-pend.
    add(8'h01, 4'h0, P, 32'h00, P, 32'h01, 1'b0);
    add(8'h00, 4'h0, P, 32'h00, P, 32'h01, 1'b0);
    add(8'h01, 4'hF, P, 32'h01, P, 32'h01, 1'b0);
    add(8'h01, 4'hF, P, 32'h01, P, 32'h00, 1'b0);
    // Global enable gating with everything pending and enabled.
    add(8'h00, 4'h1, C, 32'h00, C, 32'h00, 1'b0);
    add(8'hFF, 4'hF, E, 32'hFF, V, 32'h8000_0000, 1'b0);
    add(8'hFF, 4'h0, P, 32'h00, P, 32'hFF, 1'b0);
    add(8'hFF, 4'h1, C, 32'h01, C, 32'h01, 1'b0);
    add(8'hFF, 4'h0, P, 32'h00, V, 32'h8000_0000, 1'b1);
    add(8'hFF, 4'hF, P, 32'h0F, P, 32'hF0, 1'b1);
    add(8'hFF, 4'h0, P, 32'h00, V, 32'h8000_0004, 1'b1);
    // Byte lanes, dropped upper bits, ignored VECTOR writes, CONTROL lane 0 only.
    add(8'hFF, 4'h2, E, 32'h00, E, 32'hFF, 1'b1);
    add(8'hFF, 4'hF, E, 32'hFFFF_FF0F, E, 32'h0F, 1'b1);
    add(8'hFF, 4'h0, P, 32'h00, V, 32'h00, 1'b0);
    add(8'hFF, 4'hF, C, 32'hFFFF_FFFE, C, 32'h00, 1'b0);
    add(8'hFF, 4'hF, V, 32'hFFFF_FFFF, E, 32'h0F, 1'b0);
    add(8'hFF, 4'h2, C, 32'h01, C, 32'h00, 1'b0);
    // Enabling an already-pending source raises irq once globally enabled.
    add(8'hFF, 4'h1, E, 32'hF0, V, 32'h8000_0004, 1'b0);
    add(8'hFF, 4'h1, C, 32'h01, P, 32'hF0, 1'b0);
    add(8'hFF, 4'h0, P, 32'h00, V, 32'h8000_0004, 1'b1);

    bus.wr = 4'h0; bus.rd = 1'b0; bus.select = 1'b0; bus.addr = P; bus.data_in = 32'h0;

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk(100, P, 32'h0, 1'b0);
    chk(101, E, 32'h0, 1'b0);
    chk(102, V, 32'h0, 1'b0);
    chk(103, C, 32'h0, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    drive(8'h01, 4'h0, P, 32'h0);
    chk(104, P, 32'h01, 1'b0);
    drive(8'h01, 4'hF, E, 32'h01);
    drive(8'h01, 4'h1, C, 32'h01);
    drive(8'h01, 4'h0, P, 32'h0);
    chk(105, V, 32'h8000_0000, 1'b1);

    // Asynchronous reset between clock edges, with a source still high.
    #1;
    reset = 1'b1;
    #1;
    chk(106, P, 32'h0, 1'b0);
    chk(107, E, 32'h0, 1'b0);
    chk(108, V, 32'h0, 1'b0);
    chk(109, C, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(8'h01, 4'h0, P, 32'h0);
    chk(110, P, 32'h01, 1'b0);
    drive(8'h00, 4'hF, P, 32'h01);
    chk(111, P, 32'h00, 1'b0);

    foreach (vecs[k]) begin
      expect_push(k, vecs[k].chk, vecs[k].exp_d, vecs[k].exp_irq);
      drive(vecs[k].src, vecs[k].wr, vecs[k].addr, vecs[k].wdata);
      check_pop();
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d leftover entries want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
